// File: rtl/wave_shaper_pkg.sv
// wave_shaper_pkg: wave encodings, full-scale constants and quarter-sine table generator
package wave_shaper_pkg;
  typedef enum logic [1:0] {WAVE_SAW, WAVE_SQUARE, WAVE_TRI, WAVE_SINE} wave_e;
  localparam logic [15:0] FS_POS = 16'h7FFF;
  localparam logic [15:0] FS_NEG = 16'h8001;
  localparam logic [15:0] FS_MID = 16'h8000;
  localparam logic [15:0] PW_DEFAULT = 16'h8000;
  localparam longint PI_FX = 64'sd3373259426;
  function automatic logic [14:0] sine_entry(input int k, input int aw);
    longint x, t, s, r;
    x = (PI_FX * longint'(2 * k + 1)) >>> (aw + 2);
    t = x;
    s = x;
    for (int n = 1; n <= 6; n++) begin
      t = (t * x) >>> 30;
      t = (t * x) >>> 30;
      t = -t / longint'((2 * n) * (2 * n + 1));
      s = s + t;
    end
    r = (s * 32767 + (longint'(1) <<< 29)) >>> 30;
    return (r > 32767) ? 15'h7FFF : 15'(r);
  endfunction
endpackage

// File: rtl/wave_shaper_sine_quarter_rom.sv
// sine_quarter_rom: synchronous quarter-wave sine magnitude table built at elaboration
module sine_quarter_rom
  import wave_shaper_pkg::*;
#(
  parameter int LUT_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic [LUT_ADDR_W-1:0] addr,
  output logic [14:0]           data
);
  logic [14:0] lut [2**LUT_ADDR_W];
  for (genvar k = 0; k < 2**LUT_ADDR_W; k++) begin : g_lut
    assign lut[k] = sine_entry(k, LUT_ADDR_W);
  end
  always_ff @(posedge clk) data <= lut[addr];
endmodule

// File: rtl/wave_shaper.sv
// wave_shaper: 3-stage phase-to-sample shaper (saw/square/tri/sine); PULSE_WIDTH_EN adds i_pw
module wave_shaper
  import wave_shaper_pkg::*;
#(
  parameter int LUT_ADDR_W = 8
) (
  input  logic        i_clk5MHz,
  input  logic        i_rst,
  input  logic [15:0] i_phase,
  input  logic [1:0]  i_wave_sel,
`ifdef PULSE_WIDTH_EN
  input  logic [15:0] i_pw,
`endif
  output logic [15:0] o_sample,
  output logic        o_valid,
  output logic        o_cycle_start
);
  logic [15:0] phase_prev, p1, saw2, sq2, tri2, tri_u, pw_now, sine3, mux3;
  logic w1, v1, w2, v2, neg2, wrap;
  wave_e sel_active, sel2;
  logic [LUT_ADDR_W-1:0] idx, rom_addr;
  logic [14:0] rom_q;
`ifdef PULSE_WIDTH_EN
  logic [15:0] pw_active;
  assign pw_now = pw_active;
  always_ff @(posedge i_clk5MHz)
    if (i_rst) pw_active <= PW_DEFAULT;
    else if (wrap) pw_active <= i_pw;
`else
  assign pw_now = PW_DEFAULT;
`endif
  assign wrap = i_phase < phase_prev;
  // sel_active/pw_active update on the same edge as p1, so they describe p1
  always_ff @(posedge i_clk5MHz)
    if (i_rst) begin
      phase_prev <= '0;
      p1 <= '0;
      w1 <= 1'b0;
      v1 <= 1'b0;
      sel_active <= WAVE_SAW;
    end else begin
      phase_prev <= i_phase;
      p1 <= i_phase;
      w1 <= wrap;
      v1 <= 1'b1;
      if (wrap) sel_active <= wave_e'(i_wave_sel);
    end
  assign idx = p1[13 -: LUT_ADDR_W];
  assign rom_addr = p1[14] ? ~idx : idx;
  assign tri_u = p1[15] ? ~{p1[14:0], 1'b0} : {p1[14:0], 1'b0};
  sine_quarter_rom #(.LUT_ADDR_W(LUT_ADDR_W)) u_rom (
    .clk (i_clk5MHz),
    .addr(rom_addr),
    .data(rom_q)
  );
  always_comb begin
    sine3 = neg2 ? -{1'b0, rom_q} : {1'b0, rom_q};
    mux3 = sel2 == WAVE_SAW ? saw2 : sel2 == WAVE_SQUARE ? sq2 : sel2 == WAVE_TRI ? tri2 : sine3;
  end
  always_ff @(posedge i_clk5MHz)
    if (i_rst) begin
      saw2 <= '0;
      sq2 <= '0;
      tri2 <= '0;
      neg2 <= 1'b0;
      w2 <= 1'b0;
      v2 <= 1'b0;
      sel2 <= WAVE_SAW;
      o_sample <= '0;
      o_cycle_start <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      saw2 <= p1 ^ FS_MID;
      sq2 <= (p1 < pw_now) ? FS_POS : FS_NEG;
      tri2 <= tri_u ^ FS_MID;
      neg2 <= p1[15];
      w2 <= w1;
      v2 <= v1;
      sel2 <= sel_active;
      o_sample <= v2 ? mux3 : '0;
      o_cycle_start <= v2 & w2;
      o_valid <= v2;
    end
endmodule

// File: tb/tb_wave_shaper.sv
// tb_wave_shaper: table-driven directed checks of wave_shaper plus reset/latency sequences
module tb_wave_shaper;
  typedef struct {
    logic [15:0] phase;
    logic [1:0]  sel;
    logic [15:0] pw;
    logic [15:0] exp;
    int          tol;
    logic        cs;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] phase = 16'h4000;
  logic [1:0] sel = 2'd0;
  logic [15:0] pw = 16'h8000;
  logic [15:0] sample;
  logic valid, cs;
  int passed = 0;
  int total = 0;
  vec_t vecs[$];
  always #100 clk = ~clk;
  wave_shaper dut (
    .i_clk5MHz    (clk),
    .i_rst        (rst),
    .i_phase      (phase),
    .i_wave_sel   (sel),
`ifdef PULSE_WIDTH_EN
    .i_pw         (pw),
`endif
    .o_sample     (sample),
    .o_valid      (valid),
    .o_cycle_start(cs)
  );
  task automatic check(input string name, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    total++;
    if ((d < 0 ? -d : d) <= tol) passed++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic [15:0] p, input logic [1:0] s, input logic [15:0] w,
                     input logic [15:0] e, input int t, input logic c);
    vecs.push_back('{p, s, w, e, t, c});
  endtask
  task automatic run(input int first, input int last);
    for (int j = first; j <= last + 2; j++) begin
      if (j <= last) begin
        phase = vecs[j].phase;
        sel = vecs[j].sel;
        pw = vecs[j].pw;
      end
      tick();
      if (j >= first + 2) begin
        check($sformatf("row%0d sample", j - 2), int'($signed(sample)),
              int'($signed(vecs[j-2].exp)), vecs[j-2].tol);
        check($sformatf("row%0d cycle_start", j - 2), int'(cs), int'(vecs[j-2].cs), 0);
        check($sformatf("row%0d valid", j - 2), int'(valid), 1, 0);
      end
    end
  endtask
  initial begin
    // rows 0-18: saw -> sine -> tri -> square -> tri -> saw, selection only at wraps
    add(16'h8000, 2'd3, 16'h8000, 16'h0000, 0, 1'b0);
    add(16'hC000, 2'd3, 16'h8000, 16'h4000, 0, 1'b0);
    add(16'h0000, 2'd3, 16'h8000, 16'd101, 1, 1'b1);
    add(16'h4000, 2'd3, 16'h8000, 16'h7FFF, 1, 1'b0);
    add(16'h8000, 2'd3, 16'h8000, 16'hFF9B, 1, 1'b0);
    add(16'hC000, 2'd3, 16'h8000, 16'h8001, 1, 1'b0);
    add(16'hFFFF, 2'd3, 16'h8000, 16'hFF9B, 1, 1'b0);
    add(16'h0000, 2'd2, 16'h8000, 16'h8000, 0, 1'b1);
    add(16'h7FFF, 2'd2, 16'h8000, 16'h7FFE, 0, 1'b0);
    add(16'h8000, 2'd1, 16'h8000, 16'h7FFF, 0, 1'b0);
    add(16'hFFFF, 2'd1, 16'h8000, 16'h8001, 0, 1'b0);
    add(16'h0000, 2'd1, 16'h8000, 16'h7FFF, 0, 1'b1);
    add(16'h7FFF, 2'd2, 16'h8000, 16'h7FFF, 0, 1'b0);
    add(16'h8000, 2'd2, 16'h8000, 16'h8001, 0, 1'b0);
    add(16'h8000, 2'd2, 16'h8000, 16'h8001, 0, 1'b0);
    add(16'h1000, 2'd2, 16'h8000, 16'hA000, 0, 1'b1);
    add(16'h2000, 2'd0, 16'h8000, 16'hC000, 0, 1'b0);
    add(16'h0010, 2'd0, 16'h8000, 16'h8010, 0, 1'b1);
    add(16'hFFFF, 2'd0, 16'h8000, 16'h7FFF, 0, 1'b0);
    // rows 19-25: captured pulse width
    add(16'hF000, 2'd1, 16'h4000, 16'h7000, 0, 1'b0);
    add(16'h0000, 2'd1, 16'h4000, 16'h7FFF, 0, 1'b1);
    add(16'h3FFF, 2'd1, 16'h1000, 16'h7FFF, 0, 1'b0);
    add(16'h4000, 2'd1, 16'h1000, 16'h8001, 0, 1'b0);
    add(16'h8000, 2'd1, 16'h1000, 16'h8001, 0, 1'b0);
    add(16'h2000, 2'd1, 16'h0000, 16'h8001, 0, 1'b1);
    add(16'h0000, 2'd1, 16'h0000, 16'h8001, 0, 1'b1);
    tick();
    tick();
    check("reset sample", int'(sample), 0, 0);
    check("reset valid", int'(valid), 0, 0);
    check("reset cycle_start", int'(cs), 0, 0);
    rst = 1'b0;
    tick();
    check("edge1 valid", int'(valid), 0, 0);
    check("edge1 sample", int'(sample), 0, 0);
    tick();
    check("edge2 valid", int'(valid), 0, 0);
    tick();
    check("edge3 valid", int'(valid), 1, 0);
    check("edge3 sample", int'($signed(sample)), -16384, 0);
    for (int i = 0; i < 4; i++) begin
      check("const cycle_start", int'(cs), 0, 0);
      tick();
    end
    run(0, 18);
    phase = 16'h0000;
    sel = 2'd3;
    tick();
    phase = 16'h1000;
    tick();
    phase = 16'h2000;
    tick();
    check("pre-reset sine", int'($signed(sample)), 101, 1);
    check("pre-reset cycle_start", int'(cs), 1, 0);
    phase = 16'h3000;
    rst = 1'b1;
    tick();
    check("midreset sample", int'(sample), 0, 0);
    check("midreset valid", int'(valid), 0, 0);
    check("midreset cycle_start", int'(cs), 0, 0);
    rst = 1'b0;
    phase = 16'h5000;
    tick();
    check("post-reset edge1 valid", int'(valid), 0, 0);
    tick();
    check("post-reset edge2 valid", int'(valid), 0, 0);
    check("post-reset edge2 sample", int'(sample), 0, 0);
    tick();
    check("post-reset valid", int'(valid), 1, 0);
    check("post-reset saw", int'($signed(sample)), -12288, 0);
    check("post-reset cycle_start", int'(cs), 0, 0);
`ifdef PULSE_WIDTH_EN
    run(19, 25);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wave_shaper.md
# wave_shaper

Converts the 16-bit phase address produced by the phase accumulator into a signed 16-bit audio sample, selectable as sawtooth, square, triangle or sine. It sits directly downstream of the accumulator in the oscillator chain and feeds the output mixer/DAC stage. Waveform changes are deferred to the next phase wrap so the output never glitches mid-cycle. Three-register pipeline: one sample per clock.

## Interface
- LUT_ADDR_W, 8, log2 of quarter-wave sine table depth (entries = 2^LUT_ADDR_W, 15-bit magnitude each); legal 4..12
- i_clk5MHz  input  1  system clock; all logic on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_phase  input  16  unsigned phase address from accumulator, new value every clock
- i_wave_sel  input  2  0 = saw, 1 = square, 2 = triangle, 3 = sine
- i_pw  input  16  square pulse-width threshold (present only with PULSE_WIDTH_EN)
- o_sample  output  16  signed two's-complement sample
- o_valid  output  1  high once the pipeline holds post-reset data
- o_cycle_start  output  1  one-clock pulse aligned with the first sample of each new waveform cycle

## Operation
- Stage 1 (edge N): register i_phase; wrap = (i_phase < phase_prev), unsigned; phase_prev <= i_phase. On wrap: sel_active <= i_wave_sel; pw_active <= i_pw (or fixed 16'h8000). The new selection applies to the wrap sample itself.
- Stage 2 (edge N+1): synchronous ROM read; saw/square/triangle computed; quadrant and wrap flag carried.
- Stage 3 (edge N+2): mux by sel_active, sine sign applied, register o_sample / o_cycle_start.
- Saw: phase ^ 16'h8000 (0 -> -32768, 16'hFFFF -> 32767).
- Square: phase < pw_active -> 16'h7FFF, else 16'h8001. pw_active = 0 -> always 16'h8001.
- Triangle: u = phase[15] ? ~{phase[14:0],1'b0} : {phase[14:0],1'b0}; sample = u ^ 16'h8000. 0 -> -32768, 16'h7FFF -> 32766, 16'h8000 -> 32767, 16'hFFFF -> -32767.
- Sine: quadrant q = phase[15:14]; idx = phase[13 -: LUT_ADDR_W]; idx mirrored (~idx) when q[0]=1; magnitude = ROM[idx]; negated when q[1]=1. ROM[k] = round(32767*sin(pi/2*(k+0.5)/2^LUT_ADDR_W)); no entry reaches 0, so no zero-sign ambiguity.
- Non-monotonic jumps (accumulator FCW change) are treated as wrap only if the new phase is numerically smaller than the previous one; equal phase (FCW = 0) is not a wrap.
- i_wave_sel / i_pw changes between wraps are ignored; only the value present on the wrap edge is taken.

## Timing
- Latency: i_phase sampled at edge N -> o_sample valid after edge N+2 (3 cycles).
- Reset (any cycle, including mid-cycle): phase_prev = 0, sel_active = 0 (saw), pw_active = 16'h8000, all pipeline registers 0, o_sample = 0, o_valid = 0, o_cycle_start = 0.
- o_valid rises after the 3rd edge following reset deassertion; o_sample and o_cycle_start forced 0 while o_valid = 0.
- First sample after reset is never a wrap (phase_prev = 0); selection stays saw until the first wrap.
- o_cycle_start and the first new-waveform sample appear on the same cycle.

## Configuration
- PULSE_WIDTH_EN defined: i_pw port exists; square threshold = pw_active captured at wrap.
- Not defined: no i_pw port; threshold fixed at 16'h8000 (50 % duty); pw_active register removed.

## Structure
- Shared package: wave-select encodings (WAVE_SAW/SQUARE/TRI/SINE), full-scale constants 16'h7FFF / 16'h8001 / 16'h8000, default threshold 16'h8000.
- One sub-module: sine_quarter_rom (parameter LUT_ADDR_W, synchronous read, 15-bit output, contents generated at elaboration or from a hex init file).

## Test plan
- Reset, then i_phase = 16'h4000 constant, sel = 0 -> o_valid rises on 3rd edge; o_sample = 16'hC000 (-16384); o_cycle_start never pulses.
- Ramp i_phase +16'h1000/clk, sel = 3 -> phase 16'h4000 gives ~32767, 16'hC000 gives ~-32767, 0 gives small positive (ROM[0]); o_cycle_start on every 16'h0000 sample, 3 cycles after input.
- Ramp with sel = 2 -> samples -32768, 32766 at 16'h7FFF, 32767 at 16'h8000, -32767 at 16'hFFFF.
- Change i_wave_sel 1 -> 2 mid-cycle -> output stays square until the wrap sample, which is first triangle value, coincident with o_cycle_start.
- PULSE_WIDTH_EN, i_pw = 16'h4000 captured at wrap -> 16'h7FFF for phase < 16'h4000, 16'h8001 otherwise; i_pw change mid-cycle has no effect until next wrap.
- Assert i_rst mid-ramp for 1 cycle -> next edge all outputs 0, o_valid 0 for 3 cycles, selection reverts to saw.
